// File: rtl/fp16_to_int_seq.sv
// Multicycle fp16 -> signed INT_W integer converter; one alignment bit per clock, start/done handshake.
// Optional build macro FP2INT_ROUND_EN selects round-to-nearest-even; the default build truncates toward zero.
module fp16_to_int_seq #(
  parameter int INT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      fp_in,
  output logic             busy,
  output logic             done,
  output logic [INT_W-1:0] int_out,
  output logic             overflow,
  output logic             invalid
);

  // state | meaning
  // IDLE  | waiting for start; last result held on the outputs
  // CLASS | classify exponent, pick shortcut or shift direction/count
  // SHIFT | align accumulator one bit per clock until cnt reaches 0
  // FIN   | apply sign/saturation, publish result with a done pulse
  typedef enum logic [1:0] {S_IDLE, S_CLASS, S_SHIFT, S_FIN} state_t;

  localparam logic signed [7:0] OVF_E = 8'(INT_W - 1);
  localparam logic [INT_W:0]    LIM   = {2'b01, {(INT_W-1){1'b0}}};

  state_t           state;
  logic             sign;
  logic [4:0]       exp_q;
  logic [INT_W:0]   acc;
  logic [4:0]       cnt;
  logic             shift_left;
  logic             sat;
  logic             ovf_q;
  logic             inv_q;
  logic             guard;
  logic             sticky;

  logic signed [7:0] e_val;
  logic              e_left;
  logic [4:0]        shift_n;
  logic              e_zero_result;
  logic [INT_W:0]    acc_r;
  logic              fin_ovf;
  logic [INT_W-1:0]  mag;
  logic [INT_W-1:0]  sat_val;

  always_comb begin
    e_val   = $signed({3'b000, exp_q}) - 8'sd15;
    e_left  = (e_val >= 8'sd10);
    shift_n = e_left ? 5'(e_val - 8'sd10) : 5'(8'sd10 - e_val);
`ifdef FP2INT_ROUND_EN
    // e==-1 still contributes a guard bit, so only e<=-2 is a guaranteed zero
    e_zero_result = (e_val < -8'sd1);
    acc_r   = acc + {{INT_W{1'b0}}, guard & (sticky | acc[0])};
    fin_ovf = sign ? (acc_r > LIM) : (acc_r >= LIM);
`else
    e_zero_result = (e_val < 8'sd0);
    acc_r   = acc;
    fin_ovf = 1'b0;
`endif
    mag     = acc_r[INT_W-1:0];
    sat_val = sign ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      sign       <= 1'b0;
      exp_q      <= '0;
      acc        <= '0;
      cnt        <= '0;
      shift_left <= 1'b0;
      sat        <= 1'b0;
      ovf_q      <= 1'b0;
      inv_q      <= 1'b0;
      guard      <= 1'b0;
      sticky     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      int_out    <= '0;
      overflow   <= 1'b0;
      invalid    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sign       <= fp_in[15];
            exp_q      <= fp_in[14:10];
            acc        <= {{(INT_W-10){1'b0}}, 1'b1, fp_in[9:0]};
            cnt        <= '0;
            shift_left <= 1'b0;
            sat        <= 1'b0;
            ovf_q      <= 1'b0;
            inv_q      <= 1'b0;
            guard      <= 1'b0;
            sticky     <= 1'b0;
            overflow   <= 1'b0;
            invalid    <= 1'b0;
            busy       <= 1'b1;
            state      <= S_CLASS;
          end
        end
        S_CLASS: begin
          if (exp_q == 5'd31) begin
            inv_q <= 1'b1;
            sat   <= 1'b1;
            state <= S_FIN;
          end else if (exp_q == 5'd0) begin
            acc   <= '0;
            state <= S_FIN;
          end else if (e_val >= OVF_E) begin
            ovf_q <= 1'b1;
            sat   <= 1'b1;
            state <= S_FIN;
          end else if (e_zero_result) begin
            acc   <= '0;
            state <= S_FIN;
          end else begin
            shift_left <= e_left;
            cnt        <= shift_n;
            state      <= (shift_n == 5'd0) ? S_FIN : S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (shift_left) begin
            acc <= acc << 1;
          end else begin
            // previous guard becomes sticky; the bit falling off now is the new guard
            acc    <= acc >> 1;
            guard  <= acc[0];
            sticky <= sticky | guard;
          end
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) state <= S_FIN;
        end
        S_FIN: begin
          if (sat || fin_ovf) int_out <= sat_val;
          else                int_out <= sign ? (-mag) : mag;
          overflow <= ovf_q | fin_ovf;
          invalid  <= inv_q;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_to_int_seq.sv
// Directed bench for fp16_to_int_seq (INT_W=16): vector table plus busy-start, back-to-back and reset sequences.
module tb_fp16_to_int_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] fp_in;
  logic        busy;
  logic        done;
  logic [15:0] int_out;
  logic        overflow;
  logic        invalid;

  int checks = 0;
  int errors = 0;

  fp16_to_int_seq #(.INT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .fp_in(fp_in),
    .busy(busy), .done(done), .int_out(int_out),
    .overflow(overflow), .invalid(invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] fp;
    logic [15:0] res;
    logic        ovf;
    logic        inv;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // start pulse sampled on one edge, then count edges until done is seen
  task automatic run(input logic [15:0] fp, output int lat);
    @(negedge clk);
    start = 1'b1;
    fp_in = fp;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  vec_t vecs[16];

  initial begin
    int lat;
    logic [15:0] r15, r38;
    int l38;
    bit seen_done;

`ifdef FP2INT_ROUND_EN
    r15 = 16'h0002; r38 = 16'h0000; l38 = 13;
`else
    r15 = 16'h0001; r38 = 16'h0000; l38 = 2;
`endif
    vecs[0]  = '{16'h3C00, 16'h0001, 1'b0, 1'b0, 12};
    vecs[1]  = '{16'hC900, 16'hFFF6, 1'b0, 1'b0, 9};
    vecs[2]  = '{16'h7800, 16'h7FFF, 1'b1, 1'b0, 2};
    vecs[3]  = '{16'h7C00, 16'h7FFF, 1'b0, 1'b1, 2};
    vecs[4]  = '{16'hFC00, 16'h8000, 1'b0, 1'b1, 2};
    vecs[5]  = '{16'h3E00, r15,      1'b0, 1'b0, 12};
    vecs[6]  = '{16'h4100, 16'h0002, 1'b0, 1'b0, 11};
    vecs[7]  = '{16'h3800, r38,      1'b0, 1'b0, l38};
    vecs[8]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 2};
    vecs[9]  = '{16'h3400, 16'h0000, 1'b0, 1'b0, 2};
    vecs[10] = '{16'h0001, 16'h0000, 1'b0, 1'b0, 2};
    vecs[11] = '{16'h6400, 16'h0400, 1'b0, 1'b0, 2};
    vecs[12] = '{16'h7000, 16'h2000, 1'b0, 1'b0, 5};
    vecs[13] = '{16'hF7FF, 16'h8010, 1'b0, 1'b0, 6};
    vecs[14] = '{16'h7BFF, 16'h7FFF, 1'b1, 1'b0, 2};
    vecs[15] = '{16'hBC00, 16'hFFFF, 1'b0, 1'b0, 12};

    reset = 1'b1;
    start = 1'b0;
    fp_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_int", {16'b0, int_out}, 0);
    chk("rst_flags", {30'b0, overflow, invalid}, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run(vecs[i].fp, lat);
      chk($sformatf("v%0d_done", i), {31'b0, done}, 1);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_int", i), {16'b0, int_out}, {16'b0, vecs[i].res});
      chk($sformatf("v%0d_ovf", i), {31'b0, overflow}, {31'b0, vecs[i].ovf});
      chk($sformatf("v%0d_inv", i), {31'b0, invalid}, {31'b0, vecs[i].inv});
      @(posedge clk); #1;
      chk($sformatf("v%0d_pulse", i), {31'b0, done}, 0);
      chk($sformatf("v%0d_hold", i), {16'b0, int_out}, {16'b0, vecs[i].res});
    end

    // back-to-back: start presented while done is high is accepted
    run(16'h7C00, lat);
    chk("b2b_first_inv", {31'b0, invalid}, 1);
    run(16'hC900, lat);
    chk("b2b_lat", lat, 9);
    chk("b2b_int", {16'b0, int_out}, 32'h0000FFF6);
    chk("b2b_inv_clr", {31'b0, invalid}, 0);

    // start while busy is ignored
    @(negedge clk);
    start = 1'b1;
    fp_in = 16'h3C00;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", {31'b0, busy}, 1);
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == 3) begin
        @(negedge clk);
        start = 1'b1;
        fp_in = 16'h7C00;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    chk("ign_lat", lat, 12);
    chk("ign_int", {16'b0, int_out}, 1);
    chk("ign_inv", {31'b0, invalid}, 0);

    // reset in the middle of SHIFT aborts without a done pulse
    run(16'hC900, lat);
    @(negedge clk);
    start = 1'b1;
    fp_in = 16'h3C00;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_int", {16'b0, int_out}, 0);
    chk("mid_rst_done", {31'b0, done}, 0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    chk("mid_rst_quiet", {31'b0, seen_done}, 0);
    run(16'hC900, lat);
    chk("post_rst_lat", lat, 9);
    chk("post_rst_int", {16'b0, int_out}, 32'h0000FFF6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
